// File: rtl/uart_cmd_receiver.sv
// uart_cmd_receiver: UART endpoint assembling 16-bit commands from RX and sending 8-bit responses on TX
module uart_cmd_receiver #(
    parameter int BAUD_DIV    = 434,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        frm_err,
    output logic        cmd_ovr
);
    localparam int CW = 12;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;
    localparam logic A_HI    = 1'b0;
    localparam logic A_LO    = 1'b1;
    localparam logic T_IDLE  = 1'b0;
    localparam logic T_SHIFT = 1'b1;

    logic          rx_s1_q, rx_s2_q;
    logic [1:0]    r_q, r_d;
    logic [CW-1:0] rc_q, rc_d;
    logic [2:0]    rb_q, rb_d;
    logic [7:0]    rsh_q, rsh_d;
    logic          r_exp, byte_vld, stop_err;
    logic          a_q, a_d;
    logic [7:0]    hi_q, hi_d;
    logic [TW-1:0] to_q, to_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          rdy_q, rdy_d, ovr_q, ovr_d, frm_q, done;
    logic          t_q, t_d, sent_q, sent_d;
    logic [9:0]    tsh_q, tsh_d;
    logic [CW-1:0] tc_q, tc_d;
    logic [3:0]    tn_q, tn_d;

    assign r_exp    = rc_q == CW'(1);
    assign byte_vld = r_q == R_STOP && r_exp && rx_s2_q;
    assign stop_err = r_q == R_STOP && r_exp && !rx_s2_q;

    assign TX        = tsh_q[0];
    assign cmd       = cmd_q;
    assign cmd_rdy   = rdy_q;
    assign tx_busy   = t_q;
    assign resp_sent = sent_q;
    assign frm_err   = frm_q;
    assign cmd_ovr   = ovr_q;

    // Two-flop synchronizer for the asynchronous RX line; idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
        end
    end

    // Receiver next state: half-bit wait to mid start bit, then one sample per bit period
    always_comb begin
        r_d   = r_q;
        rc_d  = rc_q - CW'(1);
        rb_d  = rb_q;
        rsh_d = rsh_q;
        case (r_q)
            R_IDLE: begin
                rc_d = CW'(BAUD_DIV / 2);
                if (!rx_s2_q) r_d = R_START;
            end
            R_START: if (r_exp) begin
                rc_d = CW'(BAUD_DIV);
                rb_d = 3'd0;
                r_d  = rx_s2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (r_exp) begin
                rc_d  = CW'(BAUD_DIV);
                rsh_d = {rx_s2_q, rsh_q[7:1]};
                rb_d  = rb_q + 3'd1;
                if (rb_q == 3'd7) r_d = R_STOP;
            end
            default: if (r_exp) r_d = R_IDLE;
        endcase
    end

    // Assembler next state: high byte then low byte, abandoned on timeout or framing error
    always_comb begin
        a_d   = a_q;
        hi_d  = hi_q;
        to_d  = a_q == A_LO ? to_q + TW'(1) : '0;
        cmd_d = cmd_q;
        done  = 1'b0;
        if (a_q == A_HI) begin
            if (byte_vld) begin
                hi_d = rsh_q;
                a_d  = A_LO;
            end
        end else if (byte_vld) begin
            cmd_d = {hi_q, rsh_q};
            done  = 1'b1;
            a_d   = A_HI;
        end else if (stop_err || to_q == TW'(TIMEOUT_CYC)) begin
            a_d = A_HI;
        end
        rdy_d = done | (rdy_q & ~clr_cmd_rdy);
        ovr_d = done & rdy_q;
    end

    // Transmitter next state: 10-bit frame shifted LSB first, refilled with idle-high ones
    always_comb begin
        t_d    = t_q;
        tsh_d  = tsh_q;
        tc_d   = tc_q - CW'(1);
        tn_d   = tn_q;
        sent_d = 1'b0;
        if (t_q == T_IDLE) begin
            tc_d = CW'(BAUD_DIV);
            tn_d = 4'd0;
            if (send_resp) begin
                t_d   = T_SHIFT;
                tsh_d = {1'b1, resp, 1'b0};
            end
        end else if (tc_q == CW'(1)) begin
            tc_d  = CW'(BAUD_DIV);
            tsh_d = {1'b1, tsh_q[9:1]};
            tn_d  = tn_q + 4'd1;
            if (tn_q == 4'd9) begin
                t_d    = T_IDLE;
                sent_d = 1'b1;
            end
        end
    end

    // State registers for receiver, assembler and transmitter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= R_IDLE;
            rc_q   <= '0;
            rb_q   <= '0;
            rsh_q  <= '0;
            a_q    <= A_HI;
            hi_q   <= '0;
            to_q   <= '0;
            cmd_q  <= '0;
            rdy_q  <= 1'b0;
            ovr_q  <= 1'b0;
            frm_q  <= 1'b0;
            t_q    <= T_IDLE;
            tsh_q  <= '1;
            tc_q   <= '0;
            tn_q   <= '0;
            sent_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            rc_q   <= rc_d;
            rb_q   <= rb_d;
            rsh_q  <= rsh_d;
            a_q    <= a_d;
            hi_q   <= hi_d;
            to_q   <= to_d;
            cmd_q  <= cmd_d;
            rdy_q  <= rdy_d;
            ovr_q  <= ovr_d;
            frm_q  <= stop_err;
            t_q    <= t_d;
            tsh_q  <= tsh_d;
            tc_q   <= tc_d;
            tn_q   <= tn_d;
            sent_q <= sent_d;
        end
    end
endmodule

// File: tb/tb_uart_cmd_receiver.sv
// tb_uart_cmd_receiver: directed bench for the UART command receiver at BAUD_DIV=8, TIMEOUT_CYC=200
module tb_uart_cmd_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        tx_busy, resp_sent, frm_err, cmd_ovr;

    int checks = 0;
    int errors = 0;

    logic        rdy_pre, rdy_post, frm_post, ovr_post, ovr_after;
    logic [15:0] cmd_post;

    uart_cmd_receiver #(.BAUD_DIV(8), .TIMEOUT_CYC(200)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .tx_busy(tx_busy), .resp_sent(resp_sent), .frm_err(frm_err), .cmd_ovr(cmd_ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drive one RX frame; snapshot outputs just before and just after the stop-bit sample edge
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic clr_at);
        logic [7:0] v;
        v = b;
        RX = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = v[i];
            repeat (8) @(negedge clk);
        end
        RX = stop;
        repeat (6) @(negedge clk);
        rdy_pre = cmd_rdy;
        clr_cmd_rdy = clr_at;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        rdy_post = cmd_rdy;
        cmd_post = cmd;
        frm_post = frm_err;
        ovr_post = cmd_ovr;
        @(negedge clk);
        ovr_after = cmd_ovr;
        RX = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", TX); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd got %h exp 0000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy got %b exp 0", cmd_rdy); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy); end
        checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL reset_resp_sent got %b exp 0", resp_sent); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err got %b exp 0", frm_err); end
        checks++; if (cmd_ovr !== 1'b0) begin errors++; $display("FAIL reset_cmd_ovr got %b exp 0", cmd_ovr); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cmd();
        send_byte(8'hA5, 1'b1, 1'b0);
        checks++; if (rdy_post !== 1'b0) begin errors++; $display("FAIL cmd_half_rdy got %b exp 0", rdy_post); end
        send_byte(8'h3C, 1'b1, 1'b0);
        checks++; if (rdy_pre !== 1'b0) begin errors++; $display("FAIL cmd_rdy_early got %b exp 0", rdy_pre); end
        checks++; if (rdy_post !== 1'b1) begin errors++; $display("FAIL cmd_rdy_set got %b exp 1", rdy_post); end
        checks++; if (cmd_post !== 16'hA53C) begin errors++; $display("FAIL cmd_a53c got %h exp a53c", cmd_post); end
        checks++; if (ovr_post !== 1'b0) begin errors++; $display("FAIL cmd_no_ovr got %b exp 0", ovr_post); end
        clear_rdy();
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL cmd_rdy_clr got %b exp 0", cmd_rdy); end
        checks++; if (cmd !== 16'hA53C) begin errors++; $display("FAIL cmd_hold got %h exp a53c", cmd); end
    endtask

    task automatic test_tx();
        logic [9:0] exp_bits;
        exp_bits = 10'b1_0101_1010_0;
        resp = 8'h5A;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                resp = 8'hFF;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            checks++; if (TX !== exp_bits[k]) begin errors++; $display("FAIL tx_bit%0d got %b exp %b", k, TX, exp_bits[k]); end
            repeat (3) @(negedge clk);
            checks++; if (resp_sent !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_bit%0d got sent=%b busy=%b exp sent=0 busy=1", k, resp_sent, tx_busy); end
            @(negedge clk);
        end
        checks++; if (resp_sent !== 1'b1) begin errors++; $display("FAIL tx_resp_sent got %b exp 1", resp_sent); end
        checks++; if (tx_busy !== 1'b0 || TX !== 1'b1) begin errors++; $display("FAIL tx_done got busy=%b tx=%b exp busy=0 tx=1", tx_busy, TX); end
        resp = 8'h81;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        checks++; if (tx_busy !== 1'b1 || TX !== 1'b0 || resp_sent !== 1'b0) begin errors++; $display("FAIL tx_b2b_start got busy=%b tx=%b sent=%b exp 1 0 0", tx_busy, TX, resp_sent); end
        repeat (12) @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL tx_b2b_bit0 got %b exp 1", TX); end
        repeat (8) @(negedge clk);
        checks++; if (TX !== 1'b0) begin errors++; $display("FAIL tx_b2b_bit1 got %b exp 0", TX); end
        for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_b2b_timeout got busy=%b exp 0", tx_busy); end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        for (int i = 0; i < 30; i++) begin
            seen = seen | frm_err | cmd_rdy;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_activity got %b exp 0", seen); end
    endtask

    task automatic test_frm();
        send_byte(8'h12, 1'b0, 1'b0);
        checks++; if (frm_post !== 1'b1) begin errors++; $display("FAIL frm_err_pulse got %b exp 1", frm_post); end
        checks++; if (rdy_post !== 1'b0) begin errors++; $display("FAIL frm_no_rdy got %b exp 0", rdy_post); end
        send_byte(8'h34, 1'b1, 1'b0);
        checks++; if (rdy_post !== 1'b0 || frm_post !== 1'b0) begin errors++; $display("FAIL frm_hi_only got rdy=%b frm=%b exp 0 0", rdy_post, frm_post); end
        send_byte(8'h56, 1'b1, 1'b0);
        checks++; if (rdy_post !== 1'b1 || cmd_post !== 16'h3456) begin errors++; $display("FAIL frm_cmd got rdy=%b cmd=%h exp 1 3456", rdy_post, cmd_post); end
        clear_rdy();
    endtask

    task automatic test_timeout();
        send_byte(8'hFF, 1'b1, 1'b0);
        repeat (250) @(negedge clk);
        send_byte(8'h01, 1'b1, 1'b0);
        checks++; if (rdy_post !== 1'b0 || cmd_post !== 16'h3456) begin errors++; $display("FAIL timeout_discard got rdy=%b cmd=%h exp 0 3456", rdy_post, cmd_post); end
        send_byte(8'h02, 1'b1, 1'b0);
        checks++; if (rdy_post !== 1'b1 || cmd_post !== 16'h0102) begin errors++; $display("FAIL timeout_cmd got rdy=%b cmd=%h exp 1 0102", rdy_post, cmd_post); end
        clear_rdy();
    endtask

    task automatic test_back_to_back();
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        checks++; if (rdy_post !== 1'b1 || cmd_post !== 16'h1111 || ovr_post !== 1'b0) begin errors++; $display("FAIL b2b_first got rdy=%b cmd=%h ovr=%b exp 1 1111 0", rdy_post, cmd_post, ovr_post); end
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b1);
        checks++; if (rdy_pre !== 1'b1) begin errors++; $display("FAIL b2b_pending got %b exp 1", rdy_pre); end
        checks++; if (rdy_post !== 1'b1 || cmd_post !== 16'h2222) begin errors++; $display("FAIL b2b_set_wins got rdy=%b cmd=%h exp 1 2222", rdy_post, cmd_post); end
        checks++; if (ovr_post !== 1'b1 || ovr_after !== 1'b0) begin errors++; $display("FAIL b2b_ovr_pulse got %b%b exp 10", ovr_post, ovr_after); end
    endtask

    task automatic test_reset_mid();
        resp = 8'h00;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        RX = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (TX !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_tx got tx=%b busy=%b exp 1 0", TX, tx_busy); end
        checks++; if (cmd !== 16'h0000 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_cmd got cmd=%h rdy=%b exp 0000 0", cmd, cmd_rdy); end
        checks++; if (resp_sent !== 1'b0 || frm_err !== 1'b0 || cmd_ovr !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses got %b%b%b exp 000", resp_sent, frm_err, cmd_ovr); end
        RX = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_byte(8'hBE, 1'b1, 1'b0);
        send_byte(8'hEF, 1'b1, 1'b0);
        checks++; if (rdy_post !== 1'b1 || cmd_post !== 16'hBEEF) begin errors++; $display("FAIL rst_mid_recover got rdy=%b cmd=%h exp 1 beef", rdy_post, cmd_post); end
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_tx();
        test_glitch();
        test_frm();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
